// File: rtl/piso_shift_param.sv
// Parallel-in/serial-out shifter: word accepted on load_valid&&load_ready, first bit on serial_out the next cycle.
// shift_en=0 stalls the frame; load_ready also opens on the final consumed bit so back-to-back frames have no gap.
module piso_shift_param #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     shift_en,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     last_bit,
  output logic [$clog2(WIDTH)-1:0] bit_index
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             final_bit;
  logic             load_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    final_bit  = (state == SHIFT) && (cnt == CW'(1)) && shift_en;
    load_ready = (state == IDLE) || final_bit;
    load_acc   = load_valid && load_ready;
    state_nxt  = state;
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    if (load_acc) begin
      // A load on the final consumed bit overrides the return to IDLE.
      state_nxt = SHIFT;
      sr_nxt    = data_in;
      cnt_nxt   = CW'(WIDTH);
    end else if ((state == SHIFT) && shift_en) begin
      sr_nxt  = MSB_FIRST ? (sr << 1) : (sr >> 1);
      cnt_nxt = cnt - CW'(1);
      if (cnt == CW'(1)) state_nxt = IDLE;
    end
  end

  always_comb begin
    busy       = (state == SHIFT);
    last_bit   = final_bit;
    serial_out = IDLE_LEVEL;
    bit_index  = '0;
    if (state == SHIFT) begin
      serial_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
      bit_index  = IW'(CW'(WIDTH) - cnt);
    end
  end

endmodule
